// File: rtl/dsconv_pkg.sv
// rtl/dsconv_pkg.sv - shared geometry constants and block map writer state encoding
package dsconv_pkg;
    localparam int IMG_ROWS   = 70;
    localparam int IMG_COLS   = 186;
    localparam int KSIZE      = 7;
    localparam int MAP_ROWS   = IMG_ROWS - KSIZE + 1;
    localparam int MAP_COLS   = IMG_COLS - KSIZE + 1;
    localparam int MAP_DEPTH  = MAP_ROWS * MAP_COLS;
    localparam int MAP_ADDR_W = $clog2(MAP_DEPTH);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } wr_state_t;
endpackage

// File: rtl/dsconv_map_ram.sv
// rtl/dsconv_map_ram.sv - simple dual-port map RAM, one write port, one registered read port
module dsconv_map_ram #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 11520,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/dsconv_block_map_writer.sv
// rtl/dsconv_block_map_writer.sv - gathers conv results into a dense map and replays it as a stream
module dsconv_block_map_writer #(
    parameter int DATA_W   = 18,
    parameter int MAP_ROWS = dsconv_pkg::MAP_ROWS,
    parameter int MAP_COLS = dsconv_pkg::MAP_COLS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     rd_start,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overflow
);
    import dsconv_pkg::*;

    localparam int D      = MAP_ROWS * MAP_COLS;
    localparam int ADDR_W = $clog2(D);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(D - 1);

    wr_state_t         state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_all;
    logic              ram_vld;
    logic              ram_last;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        skid_cnt;
    logic [DATA_W:0]   skid0;
    logic [DATA_W:0]   skid1;

    logic            wr_en;
    logic            rd_en;
    logic            fire;
    logic            load_out;
    logic            pop;
    logic            push;
    logic [DATA_W:0] ram_word;

    assign wr_en    = in_valid && (state == FILL);
    // Skid entries plus the read in flight never exceed two, so the skid cannot overrun.
    assign rd_en    = (state == DRAIN) && !rd_all &&
                      ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && !ram_vld));
    assign fire     = out_valid && out_ready;
    assign load_out = !out_valid || fire;
    assign pop      = load_out && (skid_cnt != 2'd0);
    assign push     = ram_vld && !(load_out && (skid_cnt == 2'd0));
    assign ram_word = {ram_last, ram_rdata};

    dsconv_map_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (D),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (in_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_all     <= 1'b0;
            ram_vld    <= 1'b0;
            ram_last   <= 1'b0;
            skid_cnt   <= 2'd0;
            skid0      <= '0;
            skid1      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (in_valid && (state != FILL)) overflow <= 1'b1;

            ram_vld  <= rd_en;
            ram_last <= rd_en && (rd_addr == LAST_ADDR);
            if (rd_en) begin
                if (rd_addr == LAST_ADDR) begin
                    rd_addr <= '0;
                    rd_all  <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end

            // Skid head has priority over the RAM word to keep arrival order.
            if (load_out) begin
                if (skid_cnt != 2'd0) begin
                    out_valid            <= 1'b1;
                    {out_last, out_data} <= skid0;
                end else if (ram_vld) begin
                    out_valid            <= 1'b1;
                    {out_last, out_data} <= ram_word;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end

            case ({pop, push})
                2'b11: begin
                    if (skid_cnt == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= ram_word;
                    end else begin
                        skid0 <= ram_word;
                    end
                end
                2'b10: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 1'b1;
                end
                2'b01: begin
                    if (skid_cnt == 2'd0) skid0 <= ram_word;
                    else                  skid1 <= ram_word;
                    skid_cnt <= skid_cnt + 1'b1;
                end
                default: ;
            endcase

            case (state)
                FILL: begin
                    if (in_valid) begin
                        if (wr_addr == LAST_ADDR) begin
                            wr_addr    <= '0;
                            state      <= FULL;
                            frame_done <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (rd_start) begin
                        state   <= DRAIN;
                        rd_addr <= '0;
                        rd_all  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (fire && out_last) begin
                        state <= FILL;
                        busy  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_dsconv_block_map_writer.sv
// tb/tb_dsconv_block_map_writer.sv - self-checking bench for dsconv_block_map_writer
module tb_dsconv_block_map_writer;
    localparam int DATA_W = 18;
    localparam int D      = 64 * 180;
    localparam logic signed [DATA_W-1:0] S_MIN = 18'sh20000;
    localparam logic signed [DATA_W-1:0] S_MAX = 18'sh1FFFF;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     rd_start;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;
    logic                     frame_done;
    logic                     busy;
    logic                     overflow;

    int n_tests;
    int n_fail;
    int out_idx;
    int gaps;
    int fd_count;
    int ready_mode;
    int cyc;
    bit started;
    logic signed [DATA_W-1:0] frame_q[$];
    logic signed [DATA_W-1:0] drain_q[$];

    dsconv_block_map_writer #(
        .DATA_W   (DATA_W),
        .MAP_ROWS (64),
        .MAP_COLS (180)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .rd_start   (rd_start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"},  64'(out_valid),  64'(0));
        check({tag, "_out_last"},   64'(out_last),   64'(0));
        check({tag, "_out_data"},   64'(out_data),   64'(0));
        check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        check({tag, "_busy"},       64'(busy),       64'(0));
        check({tag, "_overflow"},   64'(overflow),   64'(0));
    endtask

    // Scoreboard: each accepted output must be the next sample of the frame being replayed.
    task automatic monitor();
        bit              prev_stall;
        logic [DATA_W:0] prev;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'(1));
                    check("stall_data", 64'({out_last, out_data}), 64'(prev));
                end
                if (out_valid && drain_q.size() == 0)
                    check("spurious_valid", 64'(out_valid), 64'(0));
                if (frame_done) fd_count++;
                if (drain_q.size() != 0) begin
                    if (out_valid)    started = 1'b1;
                    else if (started) gaps++;
                end
                if (out_valid && out_ready && drain_q.size() != 0) begin
                    check("out_data", 64'(out_data), 64'(drain_q[0]));
                    check("out_last", 64'(out_last), 64'(drain_q.size() == 1));
                    void'(drain_q.pop_front());
                    out_idx++;
                end
                prev_stall = out_valid && !out_ready;
                prev       = {out_last, out_data};
            end
        end
    endtask

    task automatic ready_driver();
        bit pat;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            pat = (cyc % 4 == 0) || (cyc % 4 == 3);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat;
                default: out_ready = (out_idx < 3000) ? pat : ($urandom_range(3, 0) != 0);
            endcase
        end
    endtask

    task automatic fill(input int n, input int kind, input int gap_pct, input int early_a, input int early_b);
        logic signed [DATA_W-1:0] v;
        for (int k = 0; k < n; k++) begin
            if (k > 0 && gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            case (kind)
                0:       v = DATA_W'(k % (1 << 17));
                1:       v = DATA_W'($urandom);
                default: v = (k % 2 == 0) ? S_MIN : S_MAX;
            endcase
            in_valid = 1'b1;
            in_data  = v;
            rd_start = (k == early_a) || (k == early_b);
            frame_q.push_back(v);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rd_start = 1'b0;
            if (k == D - 1) begin
                check("frame_done_pulse", 64'(frame_done), 64'(1));
                check("busy_rise", 64'(busy), 64'(1));
            end
        end
    endtask

    task automatic drain(input bit timed, input bit inject);
        int n;
        logic signed [DATA_W-1:0] first;
        drain_q = frame_q;
        frame_q.delete();
        first   = drain_q[0];
        out_idx = 0;
        gaps    = 0;
        started = 1'b0;
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        n = 0;
        while (busy && n < 60000) begin
            @(posedge clk);
            n++;
            #1;
            in_valid = inject && (n == 10 || n == 20 || n == 30);
            if (timed && n == 1) check("first_valid_early", 64'(out_valid), 64'(0));
            if (timed && n == 2) begin
                check("first_valid", 64'(out_valid), 64'(1));
                check("first_data", 64'(out_data), 64'(first));
            end
        end
        in_valid = 1'b0;
        check("drain_ended", 64'(busy), 64'(0));
        if (timed) check("drain_cycles", 64'(n), 64'(D + 2));
        check("drain_count", 64'(out_idx), 64'(D));
        check("drain_gaps", 64'(gaps), 64'(0));
        check("out_valid_low", 64'(out_valid), 64'(0));
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0; out_idx = 0; gaps = 0; fd_count = 0; cyc = 0;
        ready_mode = 0; started = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; rd_start = 1'b0; out_ready = 1'b1;
        fork
            monitor();
            ready_driver();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame with early rd_start pulses, overflow in FULL and DRAIN, timed drain.
        fill(D, 0, 0, 100, D - 1);
        @(posedge clk);
        #1;
        check("frame_done_once", 64'(fd_count), 64'(1));
        check("frame_done_low", 64'(frame_done), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("early_rd_ignored", 64'(out_valid), 64'(0));
        check("full_busy", 64'(busy), 64'(1));
        check("overflow_clear", 64'(overflow), 64'(0));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        check("overflow_full", 64'(overflow), 64'(1));
        drain(1'b1, 1'b1);
        check("overflow_sticky", 64'(overflow), 64'(1));

        // Random frame starting right after the drain; reset at drain index 300.
        fill(D, 1, 10, -1, -1);
        ready_mode = 1;
        drain_q = frame_q;
        frame_q.delete();
        out_idx = 0;
        started = 1'b0;
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        n = 0;
        while (out_idx < 300 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain300_reached", 64'(out_idx >= 300), 64'(1));
        #3 rst = 1'b1;
        #1;
        check_reset("rst_drain");
        drain_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Partial fill interrupted by reset at write 5000.
        fill(5000, 1, 0, -1, -1);
        #2 rst = 1'b1;
        #1;
        check_reset("rst_fill");
        frame_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh frame of signed extremes, drained under 1,0,0,1 then random backpressure.
        ready_mode = 0;
        fd_count = 0;
        fill(D, 2, 0, -1, -1);
        @(posedge clk);
        #1;
        check("frame_done_once2", 64'(fd_count), 64'(1));
        ready_mode = 2;
        drain(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
